// File: rtl/modulo_debounce_botao_pkg.sv
// Shared types for the push-button debouncer.
// State encoding and button polarity.
package modulo_debounce_botao_pkg;

  typedef enum logic [1:0] {
    SOLTO       = 2'd0,
    CONF_PRESS  = 2'd1,
    PRESSIONADO = 2'd2,
    CONF_SOLTA  = 2'd3
  } estado_t;

  localparam logic BOTAO_ATIVO = 1'b0;

endpackage

// File: rtl/modulo_debounce_botao_sincronizador.sv
// Two-flop synchronizer with a selectable reset value.
// Brings an asynchronous level into the clock domain.
module modulo_debounce_botao_sincronizador #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic clear,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture, reset to the idle level of the input
  always_ff @(posedge clock) begin
    if (clear) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/modulo_debounce_botao.sv
// Debouncer for one active-low push button.
// Samples only on rising edges of the synced divided clock.
module modulo_debounce_botao
  import modulo_debounce_botao_pkg::*;
#(
  parameter int STABLE_TICKS = 4,
  parameter int CNT_W        = 3
) (
  input  logic clock,
  input  logic clear,
  input  logic clock_div,
  input  logic botao_n,
  output logic botao_estavel,
  output logic botao_pulso
);

  localparam logic [CNT_W-1:0] CNT_ALVO = CNT_W'(STABLE_TICKS);

  logic             botao_s;
  logic             div_s;
  logic             div_q;
  logic             tick;
  logic             pr;
  estado_t          estado;
  estado_t          estado_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [CNT_W-1:0] cnt_inc;
  logic             ultimo;
  logic             entra_press;
  logic             estavel_nx;

  modulo_debounce_botao_sincronizador #(
    .RST_VAL(1'b1)
  ) u_sync_botao (
    .clock(clock),
    .clear(clear),
    .d    (botao_n),
    .q    (botao_s)
  );

  modulo_debounce_botao_sincronizador #(
    .RST_VAL(1'b0)
  ) u_sync_div (
    .clock(clock),
    .clear(clear),
    .d    (clock_div),
    .q    (div_s)
  );

  assign tick    = div_s & ~div_q;
  assign pr      = (botao_s == BOTAO_ATIVO);
  assign cnt_inc = cnt + CNT_W'(1);
  assign ultimo  = (cnt_inc == CNT_ALVO);

  // Edge-detect register for the synced divided clock
  always_ff @(posedge clock) begin
    if (clear) div_q <= 1'b0;
    else       div_q <= div_s;
  end

  // State, confirm counter and registered outputs
  always_ff @(posedge clock) begin
    if (clear) begin
      estado        <= SOLTO;
      cnt           <= '0;
      botao_estavel <= 1'b0;
      botao_pulso   <= 1'b0;
    end else begin
      estado        <= estado_nx;
      cnt           <= cnt_nx;
      botao_estavel <= estavel_nx;
      botao_pulso   <= entra_press;
    end
  end

  // Next state: everything holds unless this is a tick cycle
  always_comb begin
    estado_nx   = estado;
    cnt_nx      = cnt;
    entra_press = 1'b0;
    if (tick) begin
      unique case (estado)
        SOLTO: begin
          if (pr) begin
            estado_nx = CONF_PRESS;
            cnt_nx    = CNT_W'(1);
          end
        end
        CONF_PRESS: begin
          if (!pr) begin
            estado_nx = SOLTO;
            cnt_nx    = '0;
          end else if (ultimo) begin
            estado_nx   = PRESSIONADO;
            cnt_nx      = '0;
            entra_press = 1'b1;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
        PRESSIONADO: begin
          if (!pr) begin
            estado_nx = CONF_SOLTA;
            cnt_nx    = CNT_W'(1);
          end
        end
        CONF_SOLTA: begin
          if (pr) begin
            estado_nx = PRESSIONADO;
            cnt_nx    = '0;
          end else if (ultimo) begin
            estado_nx = SOLTO;
            cnt_nx    = '0;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
      endcase
    end
  end

  // Output decode from the state being entered
  always_comb begin
    estavel_nx = (estado_nx == PRESSIONADO) ||
                 (estado_nx == CONF_SOLTA);
  end

endmodule

// File: tb/tb_modulo_debounce_botao.sv
// Directed bench for the button debouncer.
// clock_div runs at clock/16, button moves mid-period.
module tb_modulo_debounce_botao;

  logic clock;
  logic clear;
  logic clock_div;
  logic botao_n;
  logic botao_estavel;
  logic botao_pulso;
  logic div_en;
  int   total;
  int   bad;
  int   npulso;

  modulo_debounce_botao #(
    .STABLE_TICKS(4),
    .CNT_W       (3)
  ) dut (
    .clock        (clock),
    .clear        (clear),
    .clock_div    (clock_div),
    .botao_n      (botao_n),
    .botao_estavel(botao_estavel),
    .botao_pulso  (botao_pulso)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Divided clock: half period of 8 system clocks, can be frozen
  initial clock_div = 1'b0;
  always begin
    #80;
    if (div_en) clock_div = ~clock_div;
  end

  // Count high cycles of the pulse output
  initial npulso = 0;
  always @(negedge clock) if (botao_pulso === 1'b1) npulso++;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0b exp=%0b", tag, got, exp);
    end
  endtask

  task automatic chk_n(input string tag, input int got, input int exp);
    total++;
    assert (got == exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Wait until the outputs reflect the next tick
  task automatic tick_step();
    @(posedge clock_div);
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic set_btn(input logic v);
    @(negedge clock_div);
    botao_n = v;
  endtask

  task automatic after_pulse(input string tag);
    @(posedge clock);
    #1;
    chk(tag, botao_pulso, 1'b0);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    div_en  = 1'b1;
    clear   = 1'b1;
    botao_n = 1'b0;

    // 1: reset with the button held
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rst_est", botao_estavel, 1'b0);
      chk("rst_pul", botao_pulso, 1'b0);
    end
    @(negedge clock);
    clear   = 1'b0;
    botao_n = 1'b1;
    tick_step();
    tick_step();
    chk("idle_est", botao_estavel, 1'b0);

    // 2: clean press
    set_btn(1'b0);
    for (int i = 1; i <= 3; i++) begin
      tick_step();
      chk($sformatf("p2_est_t%0d", i), botao_estavel, 1'b0);
      chk($sformatf("p2_pul_t%0d", i), botao_pulso, 1'b0);
    end
    tick_step();
    chk("p2_est_t4", botao_estavel, 1'b1);
    chk("p2_pul_t4", botao_pulso, 1'b1);
    after_pulse("p2_pul_end");
    chk("p2_est_hold", botao_estavel, 1'b1);
    chk_n("p2_npulso", npulso, 1);

    // 4: one-tick release blip, then a real release
    set_btn(1'b1);
    tick_step();
    chk("blip_est", botao_estavel, 1'b1);
    set_btn(1'b0);
    tick_step();
    chk("blip_back_est", botao_estavel, 1'b1);
    chk("blip_back_pul", botao_pulso, 1'b0);
    set_btn(1'b1);
    for (int i = 1; i <= 3; i++) begin
      tick_step();
      chk($sformatf("rel_est_t%0d", i), botao_estavel, 1'b1);
    end
    tick_step();
    chk("rel_est_t4", botao_estavel, 1'b0);
    chk("rel_pul_t4", botao_pulso, 1'b0);
    chk_n("p4_npulso", npulso, 1);

    // 3: bouncing press, then held
    set_btn(1'b0);
    tick_step();
    set_btn(1'b1);
    tick_step();
    set_btn(1'b0);
    tick_step();
    chk("bnc_est_c", botao_estavel, 1'b0);
    tick_step();
    tick_step();
    chk("bnc_est_e", botao_estavel, 1'b0);
    chk("bnc_pul_e", botao_pulso, 1'b0);
    tick_step();
    chk("bnc_est_f", botao_estavel, 1'b1);
    chk("bnc_pul_f", botao_pulso, 1'b1);
    after_pulse("bnc_pul_end");
    chk_n("p3_npulso", npulso, 2);

    // 5: reset in the middle of a confirm
    set_btn(1'b1);
    repeat (4) tick_step();
    chk("p5_released", botao_estavel, 1'b0);
    set_btn(1'b0);
    repeat (3) tick_step();
    chk("p5_pre_est", botao_estavel, 1'b0);
    @(negedge clock_div);
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick_step();
      chk($sformatf("p5_est_t%0d", i), botao_estavel, 1'b0);
      chk($sformatf("p5_pul_t%0d", i), botao_pulso, 1'b0);
    end
    tick_step();
    chk("p5_est_t4", botao_estavel, 1'b1);
    chk("p5_pul_t4", botao_pulso, 1'b1);
    after_pulse("p5_pul_end");
    chk_n("p5_npulso", npulso, 3);

    // 6: divided clock frozen low, button chattering
    @(negedge clock_div);
    #10;
    div_en = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (i % 7 == 0) botao_n = ~botao_n;
      if (i % 20 == 19) begin
        chk($sformatf("frz_est_%0d", i), botao_estavel, 1'b1);
        chk($sformatf("frz_pul_%0d", i), botao_pulso, 1'b0);
      end
    end
    chk_n("frz_npulso", npulso, 3);

    // Resume and release cleanly
    botao_n = 1'b0;
    div_en  = 1'b1;
    tick_step();
    chk("res_est", botao_estavel, 1'b1);
    set_btn(1'b1);
    repeat (3) tick_step();
    chk("res_rel_t3", botao_estavel, 1'b1);
    tick_step();
    chk("res_rel_t4", botao_estavel, 1'b0);
    chk_n("final_npulso", npulso, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
